alu_mul_sequencer: RTL and testbench

- Multi-cycle unsigned multiplier controller that drives the shared 16-bit ALU (ADD opcode 4'b0000) through 16 shift-add iterations.
- Sits between the instruction decode/control unit and the ALU. It owns the ALU's A, B and ALUControl inputs while busy, and produces a 32-bit product.
- No multiplier hardware of its own: one ALU add per cycle, plus shifting in local registers.

---
 rtl/alu_mul_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_sequencer
// Brief    : Unsigned shift-add multiplier sequencing the shared ALU; optional
//            Ovf output enabled by macro MUL_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_sequencer #(
  parameter int         WIDTH     = 16,
  parameter logic [3:0] ADD_CODE  = 4'b0000,
  parameter logic [3:0] IDLE_CODE = 4'b0010
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   OpA,
  input  logic [WIDTH-1:0]   OpB,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product,
  output logic [WIDTH-1:0]   AluA,
  output logic [WIDTH-1:0]   AluB,
  output logic [3:0]         AluControl,
  input  logic [WIDTH-1:0]   AluResult,
  input  logic               AluCarry
`ifdef MUL_OVF_EN
  ,
  output logic               Ovf
`endif
);

  localparam int               CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             finish;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mplr_nxt;

  // {carry, sum, multiplier} shifted right by one each iteration
  assign acc_nxt  = {AluCarry, AluResult[WIDTH-1:1]};
  assign mplr_nxt = {AluResult[0], mplr[WIDTH-1:1]};
  assign finish   = (state == S_RUN) && (count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    AluA       = '0;
    AluB       = '0;
    AluControl = IDLE_CODE;
    case (state)
      S_IDLE: begin
        if (Start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        Busy       = 1'b1;
        AluA       = acc;
        AluB       = mplr[0] ? mcand : '0;
        AluControl = ADD_CODE;
        if (count == LAST_CNT) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        Done = 1'b1;
        if (Start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      mplr    <= '0;
      mcand   <= '0;
      count   <= '0;
      Product <= '0;
`ifdef MUL_OVF_EN
      Ovf     <= 1'b0;
`endif
    end else if (load) begin
      mcand <= OpA;
      mplr  <= OpB;
      acc   <= '0;
      count <= '0;
    end else if (state == S_RUN) begin
      acc   <= acc_nxt;
      mplr  <= mplr_nxt;
      count <= count + 1'b1;
      if (finish) begin
        Product <= {acc_nxt, mplr_nxt};
`ifdef MUL_OVF_EN
        Ovf     <= |acc_nxt;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_mul_sequencer
// Brief    : Directed scoreboard bench for alu_mul_sequencer with an ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_control;
  logic [15:0] alu_result;
  logic        alu_carry;
`ifdef MUL_OVF_EN
  logic        ovf;
`endif

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  bit          carry_seen;
  bit          saw_done;

  always #5 clk = ~clk;

  // Reference ALU: ADD yields a carry, anything else behaves as AND
  always_comb begin
    if (alu_control == 4'b0000) begin
      {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
    end else begin
      alu_carry  = 1'b0;
      alu_result = alu_a & alu_b;
    end
  end

  alu_mul_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (start),
    .OpA        (op_a),
    .OpB        (op_b),
    .Busy       (busy),
    .Done       (done),
    .Product    (product),
    .AluA       (alu_a),
    .AluB       (alu_b),
    .AluControl (alu_control),
    .AluResult  (alu_result),
    .AluCarry   (alu_carry)
`ifdef MUL_OVF_EN
    ,
    .Ovf        (ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One multiply: start sampled at the first edge, Done expected 16 edges later
  task automatic mul(input logic [15:0] a, input logic [15:0] b,
                     input bit keep, input bit inject, input string tag);
    bit          busy_ok = 1'b1;
    bit          ctl_ok  = 1'b1;
    bit          zb_ok   = 1'b1;
    logic [31:0] exp;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    exp_q.push_back({16'h0, a} * {16'h0, b});
    tick();
    if (!keep) start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
      if (alu_control !== 4'b0000) ctl_ok = 1'b0;
      if (b == 16'h0 && alu_b !== 16'h0) zb_ok = 1'b0;
      if (alu_carry === 1'b1) carry_seen = 1'b1;
      if (keep) begin
        op_a = ~a;
        op_b = ~b;
      end
      if (inject && i == 4) begin
        start = 1'b1;
        op_a  = 16'd2;
        op_b  = 16'd2;
      end
      if (inject && i == 5) start = 1'b0;
      tick();
    end
    chk({tag, "_busy16"}, {31'h0, busy_ok}, 32'h1);
    chk({tag, "_aluctl_add"}, {31'h0, ctl_ok}, 32'h1);
    if (b == 16'h0) chk({tag, "_alub_zero"}, {31'h0, zb_ok}, 32'h1);
    chk({tag, "_done"}, {31'h0, done}, 32'h1);
    chk({tag, "_busy_off"}, {31'h0, busy}, 32'h0);
    chk({tag, "_sb_depth"}, 32'(exp_q.size()), 32'h1);
    exp = exp_q.pop_front();
    chk({tag, "_product"}, product, exp);
`ifdef MUL_OVF_EN
    chk({tag, "_ovf"}, {31'h0, ovf}, {31'h0, |exp[31:16]});
`endif
    if (!keep) begin
      tick();
      chk({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op_a  = 16'h0;
    op_b  = 16'h0;
    carry_seen = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_product", product, 32'h0);
    chk("rst_alua", {16'h0, alu_a}, 32'h0);
    chk("rst_alub", {16'h0, alu_b}, 32'h0);
    chk("rst_aluctl", {28'h0, alu_control}, 32'h2);
`ifdef MUL_OVF_EN
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
`endif

    mul(16'd3, 16'd5, 1'b0, 1'b0, "basic");

    carry_seen = 1'b0;
    mul(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "max");
    chk("max_carry_seen", {31'h0, carry_seen}, 32'h1);

    chk("idle_aluctl", {28'h0, alu_control}, 32'h2);
    mul(16'h1234, 16'h0000, 1'b0, 1'b0, "zero");
    chk("zero_idle_aluctl", {28'h0, alu_control}, 32'h2);

    mul(16'd7, 16'd9, 1'b0, 1'b1, "busy_start");
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    chk("busy_start_no_second_done", {31'h0, saw_done}, 32'h0);
    chk("busy_start_product_hold", product, 32'd63);

    op_a  = 16'd100;
    op_b  = 16'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    chk("midrst_product", product, 32'h0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    chk("midrst_no_done", {31'h0, saw_done}, 32'h0);
    chk("midrst_product_hold", product, 32'h0);
    mul(16'd10, 16'd10, 1'b0, 1'b0, "after_rst");

    mul(16'd2, 16'd3, 1'b1, 1'b0, "b2b_first");
    mul(16'd4, 16'd5, 1'b0, 1'b0, "b2b_second");
    chk("final_idle_busy", {31'h0, busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
